rr_stream_mux: RTL and testbench

- Parametrised N:1 stream multiplexer with a registered output stage.
- Selects one of CHANNELS valid/ready input streams. Arbitration is round-robin or fixed-priority, chosen at run time. The winning beat is registered toward a single output stream.
- Successor to the combinational 2:1 word multiplexer. Adds channel count, arbitration, handshake flow control and one pipeline stage.
- Sits between multiple producers (PE result ports, memory read ports) and a shared consumer bus.
- The data selection tree is built from 2:1 multiplexer instances.

---
 rtl/rr_stream_mux.sv | 118 +++++++++++
 tb/tb_rr_stream_mux.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream mux with round-robin or fixed-priority arbitration and one output register.
// Input-accept to out_valid is one cycle; a stalled output beat holds and drops every in_ready.

module rr_stream_mux_mux2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

module rr_stream_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int NP = 1 << SEL_W;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  assign load = !out_valid || out_ready;
  assign xfer = load && gnt_any;

  // Round-robin is the lowest valid index at or above ptr, falling back to the
  // lowest valid index overall; fixed priority lets the first pass see every channel.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i] && (mode || i >= int'(ptr))) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(i);
      end
    end
    if (!gnt_any) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = load && gnt_any && (gnt_idx == SEL_W'(i));
    end
  end

  // Binary select tree: level 0 holds the zero-padded channel words, each
  // higher level halves the count using one bit of the grant index.
  for (genvar l = 0; l <= SEL_W; l++) begin : stage
    logic [(NP >> l)-1:0][WIDTH-1:0] lvl;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < NP; i++) begin : g_word
        if (i < CHANNELS) begin : g_real
          assign lvl[i] = in_data[i*WIDTH +: WIDTH];
        end else begin : g_pad
          assign lvl[i] = '0;
        end
      end
    end else begin : g_node
      for (genvar j = 0; j < (NP >> l); j++) begin : g_mux
        rr_stream_mux_mux2 #(.WIDTH(WIDTH)) u_mux2 (
          .a   (stage[l-1].lvl[2*j]),
          .b   (stage[l-1].lvl[2*j+1]),
          .sel (gnt_idx[l-1]),
          .y   (lvl[j])
        );
      end
    end
  end

  assign sel_data = stage[SEL_W].lvl[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else begin
      if (load) begin
        out_valid <= gnt_any;
        if (gnt_any) begin
          out_data <= sel_data;
          out_chan <= gnt_idx;
        end
      end
      if (xfer && !mode) begin
        ptr <= (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: a 4-channel and a 3-channel instance with hand-computed expectations.

module tb_rr_stream_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  rr_stream_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(1'b0), .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] chan, input logic [7:0] dat);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_chan"}, 32'(out_chan), 32'(chan));
    chk({tag, "_data"}, 32'(out_data), 32'(dat));
  endtask

  initial begin
    rst        = 1'b1;
    mode       = 1'b0;
    in_valid   = 4'b0000;
    in_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready  = 1'b1;
    in_valid3  = 3'b000;
    in_data3   = {8'hB2, 8'hB1, 8'hB0};
    out_ready3 = 1'b1;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'b0000);
    chk("rst_valid3", 32'(out_valid3), 32'd0);

    // Round-robin saturation: grants 0,1,2,3,0,1
    in_valid = 4'b1111;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_out($sformatf("rr_beat%0d", k), 2'(k % 4), 8'hA0 + 8'(k % 4));
      chk($sformatf("rr_ready%0d", k), 32'(in_ready), 32'(4'b0001 << ((k + 1) % 4)));
    end

    // Backpressure for 3 cycles: beat from channel 1 held, nothing accepted
    out_ready = 1'b0;
    #1;
    chk("bp_ready_now", 32'(in_ready), 32'b0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_out($sformatf("bp_hold%0d", k), 2'd1, 8'hA1);
      chk($sformatf("bp_ready%0d", k), 32'(in_ready), 32'b0000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b0100);
    @(negedge clk);
    chk_out("bp_next", 2'd2, 8'hA2);

    // Fixed priority with valid 1010: channel 1 every cycle, pointer stays at 3
    mode     = 1'b1;
    in_valid = 4'b1010;
    #1;
    chk("fp_ready_now", 32'(in_ready), 32'b0010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_out($sformatf("fp_beat%0d", k), 2'd1, 8'hA1);
      chk($sformatf("fp_ready%0d", k), 32'(in_ready), 32'b0010);
    end

    // Back to round-robin: ptr = 3 with valid 0111 wraps to channel 0
    mode     = 1'b0;
    in_valid = 4'b0111;
    #1;
    chk("mode_sw_ready", 32'(in_ready), 32'b0001);
    @(negedge clk);
    chk_out("mode_sw_beat", 2'd0, 8'hA0);
    chk("mode_sw_next_ready", 32'(in_ready), 32'b0010);

    // Stall, then asynchronous reset between edges
    out_ready = 1'b0;
    #1;
    chk("ar_stall_ready", 32'(in_ready), 32'b0000);
    @(negedge clk);
    chk_out("ar_held", 2'd0, 8'hA0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid_drop", 32'(out_valid), 32'd0);
    chk("ar_data_clr", 32'(out_data), 32'h00);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b1001;
    #1;
    chk("ar_first_ready", 32'(in_ready), 32'b0001);
    @(negedge clk);
    chk_out("ar_first_beat", 2'd0, 8'hA0);
    in_valid = 4'b0000;

    // Three channels: wrap from 2 back to 0, never index 3
    in_valid3 = 3'b111;
    #1;
    chk("np2_first_ready", 32'(in_ready3), 32'b001);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("np2_valid%0d", k), 32'(out_valid3), 32'd1);
      chk($sformatf("np2_chan%0d", k), 32'(out_chan3), 32'(k % 3));
      chk($sformatf("np2_data%0d", k), 32'(out_data3), 32'(8'hB0 + 8'(k % 3)));
    end
    in_valid3 = 3'b000;
    @(negedge clk);
    chk("np2_idle_valid", 32'(out_valid3), 32'd0);
    chk("np2_idle_hold", 32'(out_chan3), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
